// File: rtl/seq_writeback.sv
// SEQ Y86-64 write-back stage: 15-entry register file, two combinational read ports, status FSM.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module seq_writeback #(
  parameter int unsigned STACK_TOP = 1023,
  parameter int unsigned WIDTH     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       icode,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic             cnd,
  input  logic [WIDTH-1:0] valE,
  input  logic [WIDTH-1:0] valM,
  input  logic             instr_valid,
  input  logic             imem_err,
  input  logic             dmem_err,
  input  logic [3:0]       srcA,
  input  logic [3:0]       srcB,
  output logic [WIDTH-1:0] valA_rd,
  output logic [WIDTH-1:0] valB_rd,
  output logic [2:0]       stat,
  output logic             halted
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]      retired
`endif
);

  localparam int unsigned NREG  = 15;
  localparam logic [3:0]  RNONE = 4'hF;
  localparam logic [3:0]  RRSP  = 4'h4;

  typedef enum logic [2:0] {
    AOK = 3'd1,
    HLT = 3'd2,
    ADR = 3'd3,
    INS = 3'd4
  } stat_e;

  stat_e            state, state_next;
  logic             fault_c, commit_c;
  logic [3:0]       dst_e_c, dst_m_c;
  logic [WIDTH-1:0] regs [NREG];

  // Destination decode; 0xF means no write on that port.
  always_comb begin
    dst_e_c = RNONE;
    dst_m_c = RNONE;
    unique case (icode)
      4'h2:                      dst_e_c = cnd ? rB : RNONE;
      4'h3, 4'h6:                dst_e_c = rB;
      4'h8, 4'h9, 4'hA:          dst_e_c = RRSP;
      4'hB: begin
        dst_e_c = RRSP;
        dst_m_c = rA;
      end
      4'h5:                      dst_m_c = rA;
      default: ;
    endcase
  end

  // Status next-state and commit qualification.
  always_comb begin
    state_next = state;
    fault_c    = imem_err || dmem_err || !instr_valid;
    commit_c   = (state == AOK) && !fault_c;
    if (state == AOK) begin
      if (imem_err || dmem_err)  state_next = ADR;
      else if (!instr_valid)     state_next = INS;
      else if (icode == 4'h0)    state_next = HLT;
      else                       state_next = AOK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= AOK;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      halted <= (state_next != AOK);
    end
  end

  assign stat = state;

  // Register array; the valM port is written last so it wins on popq %rsp.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= (i == 4) ? WIDTH'(STACK_TOP) : '0;
      end
    end else if (commit_c) begin
      if (dst_e_c != RNONE) regs[dst_e_c] <= valE;
      if (dst_m_c != RNONE) regs[dst_m_c] <= valM;
    end
  end

  // No write-to-read bypass: reads see the pre-edge array contents.
  assign valA_rd = (srcA == RNONE) ? '0 : regs[srcA];
  assign valB_rd = (srcB == RNONE) ? '0 : regs[srcB];

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)           retired <= '0;
    else if (commit_c) retired <= retired + 32'd1;
  end
`endif

endmodule

// File: tb/tb_seq_writeback.sv
// Self-checking bench for seq_writeback: directed instruction stream, a spec-level register/status
// model compared every negedge, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_seq_writeback;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   icode, rA, rB, srcA, srcB;
  logic         cnd, instr_valid, imem_err, dmem_err;
  logic [W-1:0] valE, valM, valA_rd, valB_rd;
  logic [2:0]   stat;
  logic         halted;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0]  retired;
`endif

  int checks = 0;
  int errors = 0;

  seq_writeback #(.STACK_TOP(1023), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
    .valE(valE), .valM(valM), .instr_valid(instr_valid), .imem_err(imem_err),
    .dmem_err(dmem_err), .srcA(srcA), .srcB(srcB), .valA_rd(valA_rd),
    .valB_rd(valB_rd), .stat(stat), .halted(halted)
`ifdef WB_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: architectural state as plain arrays and integers.
  logic [W-1:0] m_regs [15];
  int           m_stat;
  logic [31:0]  m_ret;
  bit           m_ok = 0;

  function automatic logic [W-1:0] m_read(input logic [3:0] a);
    return (a == 4'hF) ? '0 : m_regs[a];
  endfunction

  always @(posedge clk) begin
    int de, dm;
    bit bad;
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = (i == 4) ? 64'd1023 : 64'd0;
      m_stat = 1;
      m_ret  = 0;
      m_ok   = 1;
    end else if (m_ok && m_stat == 1) begin
      bad = imem_err || dmem_err || !instr_valid;
      if (!bad) begin
        de = 15; dm = 15;
        if (icode == 2 && cnd) de = rB;
        if (icode == 3 || icode == 6) de = rB;
        if (icode inside {8, 9, 10, 11}) de = 4;
        if (icode == 5 || icode == 11) dm = rA;
        if (de != 15) m_regs[de] = valE;
        if (dm != 15) m_regs[dm] = valM;
        m_ret = m_ret + 1;
      end
      if (imem_err || dmem_err) m_stat = 3;
      else if (!instr_valid)    m_stat = 4;
      else if (icode == 0)      m_stat = 2;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("model_stat", 64'(stat), 64'(m_stat));
      chk("model_halted", 64'(halted), 64'(m_stat != 1));
      chk("model_valA", valA_rd, m_read(srcA));
      chk("model_valB", valB_rd, m_read(srcB));
`ifdef WB_RETIRE_CNT_EN
      chk("model_retired", 64'(retired), 64'(m_ret));
`endif
    end
  end

  task automatic ins(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                     input logic [W-1:0] e, input logic [W-1:0] m, input logic c = 1'b1,
                     input logic v = 1'b1, input logic ie = 1'b0, input logic dme = 1'b0);
    icode = ic; rA = a; rB = b; valE = e; valM = m; cnd = c;
    instr_valid = v; imem_err = ie; dmem_err = dme;
    @(posedge clk); #1;
  endtask

  task automatic nop();
    ins(4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] b);
    srcA = a; srcB = b; #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; srcA = 4'hF; srcB = 4'hF;
    icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b1; valE = '0; valM = '0;
    instr_valid = 1'b1; imem_err = 1'b0; dmem_err = 1'b0;
    @(posedge clk); #1;
    // Reset values, swept while reset is held so the array stays still.
    for (int i = 0; i < 15; i++) begin
      rd(4'(i), 4'(14 - i));
      chk("reset_valA", valA_rd, (i == 4) ? 64'd1023 : 64'd0);
      chk("reset_valB", valB_rd, (i == 10) ? 64'd1023 : 64'd0);
    end
    chk("reset_stat", 64'(stat), 64'd1);
    chk("reset_halted", 64'(halted), 64'd0);
    rst = 1'b0;

    // irmovq then OPq into reg 2; a same-cycle read sees the old value.
    rd(4'd2, 4'hF);
    ins(4'h3, 4'hF, 4'd2, 64'h55, 64'h0);
    chk("irmovq_r2", valA_rd, 64'h55);
    icode = 4'h6; valE = 64'hAA; #1;
    chk("no_bypass_r2", valA_rd, 64'h55);
    ins(4'h6, 4'hF, 4'd2, 64'hAA, 64'h0);
    chk("opq_r2", valA_rd, 64'hAA);

    // popq %rsp: valM wins over valE.
    rd(4'd4, 4'd5);
    ins(4'hB, 4'd4, 4'hF, 64'd1031, 64'h77);
    chk("popq_rsp", valA_rd, 64'h77);
    // popq %rbp: both ports write.
    ins(4'hB, 4'd5, 4'hF, 64'h1000, 64'h1234);
    chk("popq_rbp_rsp", valA_rd, 64'h1000);
    chk("popq_rbp_val", valB_rd, 64'h1234);

    // cmov not taken, then taken.
    rd(4'd3, 4'hF);
    ins(4'h2, 4'd1, 4'd3, 64'h99, 64'h0, 1'b0);
    chk("cmov_nt_r3", valA_rd, 64'h0);
    ins(4'h2, 4'd1, 4'd3, 64'h99, 64'h0, 1'b1);
    chk("cmov_t_r3", valA_rd, 64'h99);

    // call updates rsp, mrmovq loads rA, rmmovq writes nothing.
    rd(4'd4, 4'd6);
    ins(4'h8, 4'hF, 4'hF, 64'h100, 64'h0);
    chk("call_rsp", valA_rd, 64'h100);
    ins(4'h5, 4'd6, 4'd1, 64'h8, 64'h66);
    chk("mrmovq_r6", valB_rd, 64'h66);
    rd(4'hF, 4'hF);
    chk("srcF_zero", valA_rd | valB_rd, 64'h0);

    // dmem fault with invalid instruction: ADR wins, nothing written, sticky.
    rd(4'd1, 4'd2);
    ins(4'h4, 4'd1, 4'd2, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("adr_stat", 64'(stat), 64'd3);
    chk("adr_halted", 64'(halted), 64'd1);
    ins(4'h3, 4'hF, 4'd1, 64'h11, 64'h0);
    chk("adr_frozen_r1", valA_rd, 64'h0);
    chk("adr_sticky", 64'(stat), 64'd3);
    ins(4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    chk("adr_sticky_halt", 64'(stat), 64'd3);

    // Reset restores AOK and rsp.
    do_reset();
    rd(4'd4, 4'd2);
    chk("rst_stat", 64'(stat), 64'd1);
    chk("rst_rsp", valA_rd, 64'd1023);
    chk("rst_r2", valB_rd, 64'h0);

    // Halt, then reset.
    ins(4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    chk("hlt_stat", 64'(stat), 64'd2);
    chk("hlt_halted", 64'(halted), 64'd1);
    ins(4'h3, 4'hF, 4'd7, 64'h7, 64'h0);
    rd(4'd7, 4'hF);
    chk("hlt_frozen_r7", valA_rd, 64'h0);
    do_reset();
    chk("rst2_stat", 64'(stat), 64'd1);

    // Halt with invalid instruction: INS wins in a single edge.
    ins(4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b1, 1'b0);
    chk("ins_over_hlt", 64'(stat), 64'd4);
    do_reset();

    // Reset mid-run discards that cycle's commit.
    rst = 1'b1;
    ins(4'h3, 4'hF, 4'd8, 64'h88, 64'h0);
    rst = 1'b0;
    rd(4'd8, 4'hF);
    chk("rst_discard_r8", valA_rd, 64'h0);

    // Five legal instructions then an imem fault.
    do_reset();
    for (int i = 0; i < 5; i++) ins(4'h3, 4'hF, 4'(i + 9), 64'(i + 1), 64'h0);
    rd(4'd13, 4'd9);
    chk("r13", valA_rd, 64'd5);
    ins(4'h3, 4'hF, 4'd10, 64'hDEAD, 64'h0, 1'b1, 1'b1, 1'b1);
    rd(4'd10, 4'hF);
    chk("imem_stat", 64'(stat), 64'd3);
    chk("imem_frozen_r10", valA_rd, 64'd2);
`ifdef WB_RETIRE_CNT_EN
    chk("retired_5", 64'(retired), 64'd5);
    do_reset();
    force dut.retired = 32'hFFFF_FFFF;
    release dut.retired;
    m_ret = 32'hFFFF_FFFF;
    nop();
    chk("retired_wrap", 64'(retired), 64'd0);
`endif
    do_reset();
    nop();
    nop();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
